// File: rtl/mema_read_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mema_seq_pkg
// Description : Shared widths, lane count and FSM state encodings for the
//               matrix-A read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package mema_seq_pkg;

    localparam int c_LANES        = 4;
    localparam int c_MULT_W       = 32;
    localparam int c_MEM_A_HEIGHT = 2000;
    localparam int c_ADDR_W       = $clog2(c_MEM_A_HEIGHT) + 1;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_LOAD   = 2'd1;
    localparam logic [1:0] c_ST_STREAM = 2'd2;
    localparam logic [1:0] c_ST_FIN    = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mema_read_sequencer_lane_chunk_counter.sv
`default_nettype none
// ============================================================================
// Module      : mema_lane_chunk_counter
// Description : One lane's chunk issuer. On load it restarts at chunk 1; while
//               running it issues one chunk per ready cycle up to multiples.
// Revision    : 1.0 - initial release
// ============================================================================
module mema_lane_chunk_counter
    import mema_seq_pkg::*;
#(
    parameter int MULT_W = c_MULT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              run,
    input  logic              ready,
    input  logic [MULT_W-1:0] multiples,
    output logic              chunk_valid,
    output logic [MULT_W-1:0] chunk_index,
    output logic              lane_done
);

    localparam logic [MULT_W-1:0] c_ONE = {{(MULT_W-1){1'b0}}, 1'b1};

    logic [MULT_W-1:0] r_counter;
    logic              r_valid;
    logic [MULT_W-1:0] r_index;
    logic              r_done;

    // Counter holds at multiples once the final chunk is issued, so it never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_counter <= '0;
            r_valid   <= 1'b0;
            r_index   <= '0;
            r_done    <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            if (load) begin
                r_counter <= c_ONE;
                r_done    <= (multiples == '0);
            end else if (run && !r_done && ready) begin
                r_valid <= 1'b1;
                r_index <= r_counter;
                if (r_counter == multiples) begin
                    r_done <= 1'b1;
                end else begin
                    r_counter <= r_counter + c_ONE;
                end
            end
        end
    end

    assign chunk_valid = r_valid;
    assign chunk_index = r_index;
    assign lane_done   = r_done;

endmodule
`default_nettype wire

// File: rtl/mema_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mema_read_sequencer
// Description : Steps the memA row address over a job's block of rows, pulses
//               read_preprocess per row and lets every lane stream its chunk
//               indices before moving to the next row.
// Revision    : 1.0 - initial release
// ============================================================================
module mema_read_sequencer
    import mema_seq_pkg::*;
#(
    parameter int NO_OF_ROW_BY_VECTOR_MODULES  = c_LANES,
    parameter int MULTIPLES_MEMORY_VALUE_WIDTH = c_MULT_W,
    parameter int MEMORY_A_HEIGHT              = c_MEM_A_HEIGHT,
    parameter int ADDRESS_WIDTH                = $clog2(MEMORY_A_HEIGHT) + 1
) (
    input  logic                                                          clk,
    input  logic                                                          reset,
    input  logic                                                          start,
    input  logic [ADDRESS_WIDTH-1:0]                                      base_address,
    input  logic [ADDRESS_WIDTH-1:0]                                      row_count,
    input  logic [NO_OF_ROW_BY_VECTOR_MODULES*MULTIPLES_MEMORY_VALUE_WIDTH-1:0] no_of_multiples,
    input  logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]                        I_am_ready,
    output logic [ADDRESS_WIDTH-1:0]                                      memA_read_address,
    output logic                                                          read_preprocess,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES-1:0]                        chunk_valid,
    output logic [NO_OF_ROW_BY_VECTOR_MODULES*MULTIPLES_MEMORY_VALUE_WIDTH-1:0] chunk_index,
    output logic                                                          busy,
    output logic                                                          done,
    output logic                                                          addr_error
);

    localparam int c_L = NO_OF_ROW_BY_VECTOR_MODULES;
    localparam int c_W = MULTIPLES_MEMORY_VALUE_WIDTH;
    localparam logic [ADDRESS_WIDTH:0]   c_HEIGHT   = (ADDRESS_WIDTH+1)'(MEMORY_A_HEIGHT);
    localparam logic [ADDRESS_WIDTH-1:0] c_ADDR_ONE = {{(ADDRESS_WIDTH-1){1'b0}}, 1'b1};

    logic [1:0]               r_state;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic [ADDRESS_WIDTH-1:0] r_rows_left;
    logic [c_L*c_W-1:0]       r_mult;
    logic                     r_pre;
    logic                     r_busy;
    logic                     r_done;
    logic                     r_err;

    logic [ADDRESS_WIDTH:0]   w_end_row;
    logic                     w_range_err;
    logic [c_L-1:0]           w_lane_done;
    logic                     w_all_done;
    logic                     w_last_row;
    logic                     w_load;
    logic                     w_run;

    // Extra bit on the sum keeps base+count from wrapping before the bound check.
    assign w_end_row   = {1'b0, base_address} + {1'b0, row_count};
    assign w_range_err = (w_end_row > c_HEIGHT);
    assign w_all_done  = &w_lane_done;
    assign w_last_row  = (r_rows_left == c_ADDR_ONE);
    assign w_load      = (r_state == c_ST_LOAD);
    assign w_run       = (r_state == c_ST_STREAM);

    // Job control: latch job, walk rows, raise done/busy/addr_error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= c_ST_IDLE;
            r_addr      <= '0;
            r_rows_left <= '0;
            r_mult      <= '0;
            r_pre       <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_pre  <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_err       <= w_range_err;
                        r_mult      <= no_of_multiples;
                        r_rows_left <= row_count;
                        if (w_range_err || (row_count == '0)) begin
                            r_state <= c_ST_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_addr  <= base_address;
                            r_state <= c_ST_LOAD;
                            r_pre   <= 1'b1;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                c_ST_LOAD: begin
                    r_state <= c_ST_STREAM;
                end
                c_ST_STREAM: begin
                    if (w_all_done) begin
                        if (w_last_row) begin
                            r_state <= c_ST_FIN;
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                        end else begin
                            r_addr      <= r_addr + c_ADDR_ONE;
                            r_rows_left <= r_rows_left - c_ADDR_ONE;
                            r_state     <= c_ST_LOAD;
                            r_pre       <= 1'b1;
                        end
                    end
                end
                c_ST_FIN: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    generate
        for (genvar i = 0; i < c_L; i++) begin : g_lane
            mema_lane_chunk_counter #(
                .MULT_W (c_W)
            ) u_lane (
                .clk         (clk),
                .reset       (reset),
                .load        (w_load),
                .run         (w_run),
                .ready       (I_am_ready[i]),
                .multiples   (r_mult[i*c_W +: c_W]),
                .chunk_valid (chunk_valid[i]),
                .chunk_index (chunk_index[i*c_W +: c_W]),
                .lane_done   (w_lane_done[i])
            );
        end
    endgenerate

    assign memA_read_address = r_addr;
    assign read_preprocess   = r_pre;
    assign busy              = r_busy;
    assign done              = r_done;
    assign addr_error        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_mema_read_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mema_read_sequencer
// Description : Directed job table plus hand-written reset sequence for the
//               matrix-A read sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mema_read_sequencer;

    logic         clk;
    logic         reset;
    logic         start;
    logic [11:0]  base_address;
    logic [11:0]  row_count;
    logic [127:0] no_of_multiples;
    logic [3:0]   I_am_ready;
    logic [11:0]  memA_read_address;
    logic         read_preprocess;
    logic [3:0]   chunk_valid;
    logic [127:0] chunk_index;
    logic         busy;
    logic         done;
    logic         addr_error;

    int errors = 0;
    int checks = 0;

    mema_read_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .start             (start),
        .base_address      (base_address),
        .row_count         (row_count),
        .no_of_multiples   (no_of_multiples),
        .I_am_ready        (I_am_ready),
        .memA_read_address (memA_read_address),
        .read_preprocess   (read_preprocess),
        .chunk_valid       (chunk_valid),
        .chunk_index       (chunk_index),
        .busy              (busy),
        .done              (done),
        .addr_error        (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // exp_lat counts edges from the edge that samples start to the edge that raises done.
    typedef struct {
        int base;
        int rows;
        int mult [4];
        int stall;
        int restart_at;
        int exp_lat;
        int exp_pre;
        int exp_err;
        int exp_chunks [4];
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_addr"},  64'(memA_read_address), 64'd0);
        chk({tag, "_pre"},   64'(read_preprocess),   64'd0);
        chk({tag, "_valid"}, 64'(chunk_valid),       64'd0);
        chk({tag, "_index"}, 64'(chunk_index == '0 ? 0 : 1), 64'd0);
        chk({tag, "_busy"},  64'(busy),              64'd0);
        chk({tag, "_done"},  64'(done),              64'd0);
        chk({tag, "_err"},   64'(addr_error),        64'd0);
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_job(input int id, input vec_t v);
        int  pre_cnt;
        int  first;
        int  last;
        int  lat;
        int  chunks [4];
        int  nxt [4];
        bit  got_done;
        pre_cnt = 0; first = -1; last = -1; lat = -1; got_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chunks[i] = 0;
            nxt[i]    = 1;
            no_of_multiples[i*32 +: 32] = 32'(v.mult[i]);
        end
        base_address = 12'(v.base);
        row_count    = 12'(v.rows);
        I_am_ready   = 4'hF;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 200 && !got_done; k++) begin
            if (k == 0) chk($sformatf("job%0d_busy_start", id), 64'(busy), 64'(v.exp_pre > 0));
            if (read_preprocess) begin
                if (pre_cnt == 0) first = int'(memA_read_address);
                last = int'(memA_read_address);
                pre_cnt++;
                for (int i = 0; i < 4; i++) nxt[i] = 1;
            end
            for (int i = 0; i < 4; i++) begin
                if (chunk_valid[i]) begin
                    chk($sformatf("job%0d_lane%0d_index", id, i), 64'(chunk_index[i*32 +: 32]), 64'(nxt[i]));
                    chk($sformatf("job%0d_lane%0d_addr_hold", id, i), 64'(memA_read_address), 64'(last));
                    nxt[i]++;
                    chunks[i]++;
                end
            end
            if (done) begin
                got_done = 1'b1;
                lat      = k;
            end else begin
                I_am_ready = (k < v.stall) ? 4'b1011 : 4'b1111;
                if (k == v.restart_at) begin
                    start        = 1'b1;
                    base_address = 12'd100;
                    row_count    = 12'd5;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
        end
        start = 1'b0;
        if (!got_done) chk($sformatf("job%0d_done_timeout", id), 64'd0, 64'd1);
        chk($sformatf("job%0d_latency", id), 64'(lat), 64'(v.exp_lat));
        chk($sformatf("job%0d_preprocess_count", id), 64'(pre_cnt), 64'(v.exp_pre));
        chk($sformatf("job%0d_addr_error", id), 64'(addr_error), 64'(v.exp_err));
        chk($sformatf("job%0d_busy_at_done", id), 64'(busy), 64'd0);
        for (int i = 0; i < 4; i++)
            chk($sformatf("job%0d_lane%0d_chunks", id, i), 64'(chunks[i]), 64'(v.exp_chunks[i]));
        if (v.exp_pre > 0) begin
            chk($sformatf("job%0d_first_addr", id), 64'(first), 64'(v.exp_first));
            chk($sformatf("job%0d_last_addr", id), 64'(last), 64'(v.exp_last));
        end
        @(negedge clk);
        chk($sformatf("job%0d_done_pulse_width", id), 64'(done), 64'd0);
        chk($sformatf("job%0d_err_sticky", id), 64'(addr_error), 64'(v.exp_err));
    endtask

    initial begin
        //           base  rows mult            stall rst lat pre err chunks          first last
        vecs[0] = '{10,   2,  '{3,3,3,3},      0,  -1, 10, 2,  0, '{6,6,6,6},      10,   11};
        vecs[1] = '{20,   1,  '{1,4,0,2},      0,  -1, 6,  1,  0, '{1,4,0,2},      20,   20};
        vecs[2] = '{30,   1,  '{2,2,2,2},      5,  -1, 8,  1,  0, '{2,2,2,2},      30,   30};
        vecs[3] = '{7,    0,  '{3,3,3,3},      0,  -1, 0,  0,  0, '{0,0,0,0},      0,    0};
        vecs[4] = '{1999, 5,  '{3,3,3,3},      0,  -1, 0,  0,  1, '{0,0,0,0},      0,    0};
        vecs[5] = '{0,    3,  '{2,1,1,1},      0,  -1, 12, 3,  0, '{6,3,3,3},      0,    2};
        vecs[6] = '{1995, 5,  '{1,1,1,1},      0,  -1, 15, 5,  0, '{5,5,5,5},      1995, 1999};
        vecs[7] = '{40,   1,  '{3,3,3,3},      0,  2,  5,  1,  0, '{3,3,3,3},      40,   40};
        vecs[8] = '{50,   2,  '{0,0,0,0},      0,  -1, 4,  2,  0, '{0,0,0,0},      50,   51};

        reset           = 1'b1;
        start           = 1'b0;
        base_address    = '0;
        row_count       = '0;
        no_of_multiples = '0;
        I_am_ready      = 4'hF;
        repeat (3) @(negedge clk);
        check_zero("reset_init");
        reset = 1'b0;

        for (int j = 0; j < 9; j++) run_job(j, vecs[j]);

        // Reset held for three cycles in the middle of a job.
        base_address = 12'd10;
        row_count    = 12'd2;
        for (int i = 0; i < 4; i++) no_of_multiples[i*32 +: 32] = 32'd3;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_job_busy", 64'(busy), 64'd1);
        reset = 1'b1;
        @(negedge clk);
        check_zero("reset_mid");
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_zero("reset_hold");
        run_job(9, vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
